raster_frame_sequencer: RTL and testbench
=========================================

RASTER_FRAME_SEQUENCER -- requirements
Module: raster_frame_sequencer

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 1023: maximum DRAIN-state cycles before a forced frame close.
REQ-002 Parameter CNT_W, default 16: width of the drain counter and the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 frame_start  input  1  one-cycle pulse from the clipper that opens a frame.
REQ-006 eoo  input  1  one-cycle end-of-objects pulse from the clipper.
REQ-007 line_valid  input  1  the clipper presents a clipped line this cycle.
REQ-008 raster_ready  input  1  the rasterizer line FIFO is not full.
REQ-009 raster_done  input  1  the line generator has finished every queued line.
REQ-010 frame_ready  input  1  the frame buffer can accept a new frame.
REQ-011 line_wr_en  output  1  accepted-line strobe to the rasterizer input stage.
REQ-012 clip_stall  output  1  the clipper must hold its current line.
REQ-013 swap_req  output  1  one-cycle request to the frame buffer to swap or display.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 frame_cnt  output  8  count of completed frames.
REQ-016 timeout_err  output  1  the last frame was force-closed by the drain timeout.

Function
REQ-017 FSM states: IDLE, WAIT_FB, ACCEPT, DRAIN, SWAP.
REQ-018 IDLE: frame_start moves the FSM to WAIT_FB; all other inputs are ignored.
REQ-019 WAIT_FB: frame_ready moves the FSM to ACCEPT; otherwise the FSM holds.
REQ-020 line_wr_en is combinational: (state==ACCEPT) & line_valid & raster_ready.
REQ-021 clip_stall is combinational: high in WAIT_FB; high in ACCEPT when raster_ready=0; low in IDLE, DRAIN and SWAP.
REQ-022 ACCEPT: eoo moves the FSM to DRAIN.
REQ-023 A line presented in the same cycle as eoo is accepted if raster_ready=1.
REQ-024 DRAIN: the drain counter clears on entry and increments each cycle.
REQ-025 DRAIN: raster_done moves the FSM to SWAP.
REQ-026 DRAIN: if the counter reaches DRAIN_TIMEOUT without raster_done, the FSM moves to SWAP and timeout_err is set.
REQ-027 raster_done and the timeout in the same cycle: treat as a normal completion; timeout_err is not set.
REQ-028 SWAP lasts exactly one cycle: swap_req=1, frame_cnt increments (8-bit wrap, 255 to 0), then the FSM returns to IDLE.
REQ-029 swap_req is registered: it is high in the cycle the FSM is in SWAP and low in every other cycle.
REQ-030 timeout_err is sticky; it clears only on the frame_start that leaves IDLE, or on reset.
REQ-031 frame_start outside IDLE is ignored and changes neither state nor counters.
REQ-032 eoo outside ACCEPT is ignored.
REQ-033 raster_done outside DRAIN is ignored.
REQ-034 Latency: frame_start to ACCEPT is at least 2 cycles (IDLE to WAIT_FB to ACCEPT) when frame_ready is already high.
REQ-035 Latency: raster_done to swap_req is 1 cycle.

Reset
REQ-036 While rst=1 at a clock edge: state is IDLE; frame_cnt, drain counter, statistics counters and timeout_err are 0.
REQ-037 While rst=1: swap_req=0; line_wr_en, clip_stall and busy are 0.
REQ-038 Reset mid-frame (any state) abandons the frame with no swap_req and no frame_cnt change.

Configuration
REQ-039 Macro RASTER_FRAME_STATS_EN defined adds two outputs: stat_lines [CNT_W-1:0] and stat_stall [CNT_W-1:0].
REQ-040 With RASTER_FRAME_STATS_EN: stat_lines counts line_wr_en pulses in the current frame.
REQ-041 With RASTER_FRAME_STATS_EN: stat_stall counts ACCEPT cycles with line_valid=1 and raster_ready=0.
REQ-042 With RASTER_FRAME_STATS_EN: both statistics counters saturate at all-ones, clear on the frame_start that leaves IDLE, and hold their values through SWAP and IDLE.
REQ-043 Without RASTER_FRAME_STATS_EN: neither the statistics ports nor their logic exist, and all other behaviour is identical.

Verification
REQ-044 Basic frame. Stimulus: rst, then frame_start with frame_ready=1, 5 lines with raster_ready=1, eoo, then raster_done 3 cycles later. Response: 5 line_wr_en pulses, one swap_req 1 cycle after raster_done, frame_cnt=1, stat_lines=5.
REQ-045 Backpressure. Stimulus: in ACCEPT, line_valid=1 and raster_ready=0 for 4 cycles. Response: clip_stall=1 and line_wr_en=0 for those 4 cycles, stat_stall=4.
REQ-046 Timeout. Stimulus: DRAIN_TIMEOUT=8, eoo, raster_done never asserted. Response: swap_req after 8 DRAIN cycles, timeout_err=1 until the next frame_start.
REQ-047 Frame-buffer wait. Stimulus: frame_start with frame_ready=0 for 10 cycles. Response: WAIT_FB, busy=1, clip_stall=1 for those 10 cycles, and no line_wr_en.
REQ-048 Mid-frame reset. Stimulus: rst asserted in DRAIN with frame_cnt=3. Response: IDLE next cycle, frame_cnt=0, no swap_req.
REQ-049 Wrap and ignored events. Stimulus: 256 frames completed; frame_start asserted during DRAIN. Response: frame_cnt back to 0; the spurious frame_start has no effect.

Source files
------------

// File: rtl/raster_frame_sequencer.sv
// rtl/raster_frame_sequencer.sv - frame sequencing FSM between clipper, rasterizer and frame buffer
// Optional statistics outputs enabled by defining RASTER_FRAME_STATS_EN.
module raster_frame_sequencer #(
  parameter int DRAIN_TIMEOUT = 1023,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             eoo,
  input  logic             line_valid,
  input  logic             raster_ready,
  input  logic             raster_done,
  input  logic             frame_ready,
  output logic             line_wr_en,
  output logic             clip_stall,
  output logic             swap_req,
  output logic             busy,
  output logic [7:0]       frame_cnt,
  output logic             timeout_err
`ifdef RASTER_FRAME_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_lines,
  output logic [CNT_W-1:0] stat_stall
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT_FB, ACCEPT, DRAIN, SWAP} state_t;

  // The counter holds k-1 in the k-th DRAIN cycle, so this value marks the last allowed cycle.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             swap_req_q, swap_req_d;

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_err_d = timeout_err_q;
    swap_req_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d       = WAIT_FB;
          timeout_err_d = 1'b0;
        end
      end
      WAIT_FB: begin
        if (frame_ready) state_d = ACCEPT;
      end
      ACCEPT: begin
        if (eoo) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        // A completion arriving on the timeout cycle wins over the timeout.
        if (raster_done) begin
          state_d    = SWAP;
          swap_req_d = 1'b1;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d       = SWAP;
          swap_req_d    = 1'b1;
          timeout_err_d = 1'b1;
        end
      end
      SWAP: begin
        state_d     = IDLE;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_wr_en  = ~rst & (state_q == ACCEPT) & line_valid & raster_ready;
  assign clip_stall  = ~rst & ((state_q == WAIT_FB) | ((state_q == ACCEPT) & ~raster_ready));
  assign busy        = ~rst & (state_q != IDLE);
  assign swap_req    = ~rst & swap_req_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_err_q;

`ifdef RASTER_FRAME_STATS_EN
  logic [CNT_W-1:0] stat_lines_q, stat_lines_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_lines_d = stat_lines_q;
    stat_stall_d = stat_stall_q;
    if ((state_q == IDLE) && frame_start) begin
      stat_lines_d = '0;
      stat_stall_d = '0;
    end else begin
      if (line_wr_en && !(&stat_lines_q)) stat_lines_d = stat_lines_q + 1'b1;
      if ((state_q == ACCEPT) && line_valid && !raster_ready && !(&stat_stall_q))
        stat_stall_d = stat_stall_q + 1'b1;
    end
  end

  assign stat_lines = stat_lines_q;
  assign stat_stall = stat_stall_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      drain_cnt_q   <= '0;
      frame_cnt_q   <= 8'd0;
      timeout_err_q <= 1'b0;
      swap_req_q    <= 1'b0;
`ifdef RASTER_FRAME_STATS_EN
      stat_lines_q  <= '0;
      stat_stall_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      swap_req_q    <= swap_req_d;
`ifdef RASTER_FRAME_STATS_EN
      stat_lines_q  <= stat_lines_d;
      stat_stall_q  <= stat_stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// tb/tb_raster_frame_sequencer.sv - scenario bench for raster_frame_sequencer
// Expected frame counts are queued at drain completion and popped once the swap has retired.
module tb_raster_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0, eoo = 1'b0, line_valid = 1'b0;
  logic        raster_ready = 1'b0, raster_done = 1'b0, frame_ready = 1'b0;
  logic        line_wr_en, clip_stall, swap_req, busy, timeout_err;
  logic [7:0]  frame_cnt;
`ifdef RASTER_FRAME_STATS_EN
  logic [15:0] stat_lines, stat_stall;
`endif

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  int exp_q[$];

  raster_frame_sequencer #(.DRAIN_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .eoo(eoo), .line_valid(line_valid),
    .raster_ready(raster_ready), .raster_done(raster_done), .frame_ready(frame_ready),
    .line_wr_en(line_wr_en), .clip_stall(clip_stall), .swap_req(swap_req), .busy(busy),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err)
`ifdef RASTER_FRAME_STATS_EN
    , .stat_lines(stat_lines), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Inputs change on the falling edge; outputs are observed 1 time unit later.
  task automatic drive(input logic fs, input logic e, input logic lv, input logic rr,
                       input logic rd, input logic fr);
    @(negedge clk);
    frame_start = fs; eoo = e; line_valid = lv; raster_ready = rr;
    raster_done = rd; frame_ready = fr;
    #1;
  endtask

  task automatic quick_frame();
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 1, 0, 1);
    drive(0, 1, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    model_cnt = (model_cnt + 1) % 256;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 1, 1, 0, 1);
    drive(0, 0, 1, 1, 0, 1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (clip_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", clip_stall); end
    total++; if (line_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", line_wr_en); end
    total++; if (swap_req !== 1'b0) begin bad++; $display("FAIL reset_swap: got %b want 0", swap_req); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_cnt = 0;
  endtask

  task automatic test_basic();
    int lines = 0;
    drive(1, 0, 0, 0, 0, 1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    drive(0, 0, 0, 0, 0, 1);
    total++; if (clip_stall !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_waitfb: got stall=%b busy=%b want 1 1", clip_stall, busy); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0, 1);
      if (line_wr_en === 1'b1) lines++;
    end
    total++; if (lines != 5) begin bad++; $display("FAIL basic_lines: got %0d want 5", lines); end
    drive(0, 1, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (swap_req !== 1'b0) begin bad++; $display("FAIL basic_early_swap: got %b want 0", swap_req); end
    drive(0, 0, 0, 0, 1, 0);
    exp_q.push_back((model_cnt + 1) % 256);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (swap_req !== 1'b1) begin bad++; $display("FAIL basic_swap: got %b want 1", swap_req); end
    drive(0, 0, 0, 0, 0, 0);
    model_cnt = exp_q.pop_front();
    total++; if (frame_cnt !== 8'(model_cnt)) begin bad++; $display("FAIL basic_cnt: got %0d want %0d", frame_cnt, model_cnt); end
    total++; if (swap_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_after: got swap=%b busy=%b want 0 0", swap_req, busy); end
`ifdef RASTER_FRAME_STATS_EN
    total++; if (stat_lines !== 16'd5) begin bad++; $display("FAIL basic_stat_lines: got %0d want 5", stat_lines); end
`endif
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    int wr = 0;
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0, 1);
      if (clip_stall === 1'b1) stalls++;
      if (line_wr_en !== 1'b0) wr++;
    end
    total++; if (stalls != 4) begin bad++; $display("FAIL bp_stall: got %0d want 4", stalls); end
    total++; if (wr != 0) begin bad++; $display("FAIL bp_wr: got %0d want 0", wr); end
    drive(0, 1, 1, 1, 0, 1);
    total++; if (line_wr_en !== 1'b1 || clip_stall !== 1'b0) begin
      bad++; $display("FAIL bp_eoo_line: got wr=%b stall=%b want 1 0", line_wr_en, clip_stall); end
    drive(0, 0, 0, 0, 1, 0);
    exp_q.push_back((model_cnt + 1) % 256);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (swap_req !== 1'b1) begin bad++; $display("FAIL bp_swap: got %b want 1", swap_req); end
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    model_cnt = exp_q.pop_front();
    total++; if (frame_cnt !== 8'(model_cnt)) begin bad++; $display("FAIL bp_cnt: got %0d want %0d", frame_cnt, model_cnt); end
`ifdef RASTER_FRAME_STATS_EN
    total++; if (stat_stall !== 16'd4) begin bad++; $display("FAIL bp_stat_stall: got %0d want 4", stat_stall); end
    total++; if (stat_lines !== 16'd1) begin bad++; $display("FAIL bp_stat_lines: got %0d want 1", stat_lines); end
`endif
  endtask

  task automatic test_mid_reset();
    int swaps = 0;
    quick_frame();
    drive(0, 0, 0, 0, 0, 0);
    total++; if (frame_cnt !== 8'(model_cnt)) begin bad++; $display("FAIL mr_pre_cnt: got %0d want %0d", frame_cnt, model_cnt); end
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mr_in_drain: got %b want 1", busy); end
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    total++; if (busy !== 1'b0 || swap_req !== 1'b0) begin
      bad++; $display("FAIL mr_during: got busy=%b swap=%b want 0 0", busy, swap_req); end
    rst = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      if (swap_req !== 1'b0) swaps++;
    end
    total++; if (swaps != 0) begin bad++; $display("FAIL mr_swaps: got %0d want 0", swaps); end
    total++; if (frame_cnt !== 8'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL mr_after: got cnt=%0d busy=%b want 0 0", frame_cnt, busy); end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit seen = 0;
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 0, 1);
    exp_q.push_back((model_cnt + 1) % 256);
    for (int i = 0; i < 40 && !seen; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (swap_req === 1'b1) seen = 1;
      else if (busy === 1'b1) n++;
    end
    total++; if (!seen || n != 8) begin bad++; $display("FAIL to_cycles: got seen=%0d n=%0d want 1 8", seen, n); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", timeout_err); end
    drive(0, 0, 0, 0, 0, 0);
    model_cnt = exp_q.pop_front();
    total++; if (frame_cnt !== 8'(model_cnt)) begin bad++; $display("FAIL to_cnt: got %0d want %0d", frame_cnt, model_cnt); end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    drive(0, 0, 0, 0, 0, 1);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", timeout_err); end
    drive(0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    exp_q.push_back((model_cnt + 1) % 256);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (swap_req !== 1'b1 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL to_tie: got swap=%b err=%b want 1 0", swap_req, timeout_err); end
    drive(0, 0, 0, 0, 0, 0);
    model_cnt = exp_q.pop_front();
    total++; if (frame_cnt !== 8'(model_cnt)) begin bad++; $display("FAIL to_tie_cnt: got %0d want %0d", frame_cnt, model_cnt); end
  endtask

  task automatic test_fb_wait();
    int good = 0;
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 1, 0, 0);
      if (busy === 1'b1 && clip_stall === 1'b1 && line_wr_en === 1'b0) good++;
    end
    total++; if (good != 10) begin bad++; $display("FAIL fb_wait: got %0d want 10", good); end
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    exp_q.push_back((model_cnt + 1) % 256);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (swap_req !== 1'b1) begin bad++; $display("FAIL fb_swap: got %b want 1", swap_req); end
    drive(0, 0, 0, 0, 0, 0);
    model_cnt = exp_q.pop_front();
    total++; if (frame_cnt !== 8'(model_cnt)) begin bad++; $display("FAIL fb_cnt: got %0d want %0d", frame_cnt, model_cnt); end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (model_cnt != 255 && guard < 300) begin
      quick_frame();
      guard++;
    end
    drive(0, 0, 0, 0, 0, 0);
    total++; if (frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    exp_q.push_back((model_cnt + 1) % 256);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (swap_req !== 1'b1) begin bad++; $display("FAIL wrap_swap: got %b want 1", swap_req); end
    drive(0, 0, 0, 0, 0, 0);
    model_cnt = exp_q.pop_front();
    total++; if (frame_cnt !== 8'(model_cnt)) begin bad++; $display("FAIL wrap_cnt: got %0d want %0d", frame_cnt, model_cnt); end
    drive(0, 0, 0, 0, 0, 0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_spurious: got busy=%b want 0", busy); end
`ifdef RASTER_FRAME_STATS_EN
    total++; if (stat_lines !== 16'd1 || stat_stall !== 16'd0) begin
      bad++; $display("FAIL wrap_stats: got lines=%0d stall=%0d want 1 0", stat_lines, stat_stall); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_mid_reset();
    test_timeout();
    test_fb_wait();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
